core_if_id_skid: RTL and testbench
==================================

Name: core_if_id_skid

Overview:
- Parametrised IF/ID pipeline register between fetch (PC/instruction memory) and decode.
- Adds a valid/ready handshake, flush, and an optional 2-entry skid buffer.
- Fetch can run while decode stalls without losing instructions; upstream ready is fully registered when the skid buffer is enabled.
- Empty slots present a NOP bubble at the reset address to decode.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction word width.
- RST_ADDR, CPURstAddress, address value loaded on reset/flush/empty.
- NOP_INST, INST_NOP (32'h00000013), instruction value loaded on reset/flush/empty.
- SKID, 1, 1 = 2-entry skid buffer; 0 = single register with combinational ready.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  discard all held and incoming instructions (branch/jump redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_addr  in  ADDR_W  fetched instruction address.
- in_inst  in  INST_W  fetched instruction word.
- out_valid  out  1  decode slot holds a real instruction.
- out_ready  in  1  decode consumes this cycle (low = stall).
- out_addr  out  ADDR_W  instruction address to decode.
- out_inst  out  INST_W  instruction word to decode.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Strict FIFO order; no duplication, no loss.
- Storage: main register (drives the out_* ports) plus a skid register (SKID=1 only).
- States: EMPTY(0), ONE(1), FULL(2); occupancy is the state encoding.
- Reset (rst=0, asynchronous): state EMPTY; main and skid hold RST_ADDR/NOP_INST; out_valid=0; out_addr=RST_ADDR; out_inst=NOP_INST; occupancy=0; in_ready=1 (SKID=1).
- out_valid = (state != EMPTY). Outputs always come directly from main register flops; there is no combinational path from in_* to out_*.
- in_ready:
  - SKID=1: in_ready = (state != FULL), registered.
  - SKID=0: in_ready = ~out_valid | out_ready; FULL is unreachable.
- Transitions, flush_i=0:
  - EMPTY, in_fire -> ONE; main <= in.
  - ONE, in_fire & out_fire -> ONE; main <= in.
  - ONE, in_fire & ~out_fire -> FULL; skid <= in (SKID=1 only).
  - ONE, ~in_fire & out_fire -> EMPTY; main <= RST_ADDR/NOP_INST.
  - FULL, out_fire -> ONE; main <= skid; skid <= RST_ADDR/NOP_INST.
  - FULL, no out_fire -> hold.
  - Any other combination -> hold.
- Latency: 1 cycle from in_fire to out_valid when entering an EMPTY or draining ONE slot. Throughput is 1 instruction/cycle while out_ready=1.
- Flush (highest priority over every transition):
  - Next state EMPTY; both entries reload RST_ADDR/NOP_INST.
  - Any in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by decode.
  - in_ready is unaffected during the flush cycle; it returns 1 the cycle after.
- Held outputs stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation drops all entries immediately (asynchronous); no partial state survives.
- Simultaneous flush and reset: reset dominates; the result is identical.

Decomposition:
- defines.v supplies InstAddressBus, InstByteBus, CPURstAddress, INST_NOP; parameter defaults derive from these.
- Add the state encodings IFID_EMPTY/IFID_ONE/IFID_FULL to defines.v.
- One sub-module: gen_en_ff_n, a width-parametrised flop with enable, asynchronous active-low reset and a reset-value input. It is instantiated for main addr/inst, skid addr/inst and the state register.

Test Plan:
- Reset, then in_valid=1, in_addr=0x0, in_inst=0x00500093, out_ready=1 -> next cycle out_valid=1, out_addr=0x0, out_inst=0x00500093, occupancy=1.
- Streaming with out_ready=1: feed addr 0x0,0x4,0x8,0xC -> outputs appear in order, one per cycle, each 1 cycle delayed; in_ready stays 1.
- SKID=1, out_ready=0 with 3 offers at 0x10,0x14,0x18 -> occupancy reaches 2, in_ready=0; out holds 0x10; 0x18 is held off. Then out_ready=1 -> 0x10, 0x14, 0x18 emerge in consecutive cycles with no loss.
- FULL state, flush_i=1 for one cycle -> next cycle out_valid=0, out_inst=0x00000013, out_addr=RST_ADDR, occupancy=0, in_ready=1; flushed entries never appear.
- Assert rst=0 asynchronously mid-stream (between clock edges) with occupancy=2 -> outputs reset immediately without a clock edge; after release the first new instruction issues normally.
- SKID=0, out_ready=0, out_valid=1 -> in_ready=0 combinationally. Raise out_ready=1 -> in_ready=1 in the same cycle; the new instruction replaces the consumed one with no bubble.

Source files
------------

// File: rtl/core_if_id_skid_pkg.sv
// Shared definitions for the IF/ID pipeline register.
// Supplies the legacy bus widths, the reset fetch address, the NOP encoding
// and the occupancy/state encodings used by core_if_id_skid.
package core_if_id_skid_pkg;

    localparam int          InstAddressBus = 32;
    localparam int          InstByteBus    = 32;
    localparam logic [31:0] CPURstAddress  = 32'h8000_0000;
    localparam logic [31:0] INST_NOP       = 32'h0000_0013;   // addi x0, x0, 0

    // State encoding doubles as the occupancy count.
    localparam logic [1:0]  IFID_EMPTY = 2'd0;
    localparam logic [1:0]  IFID_ONE   = 2'd1;
    localparam logic [1:0]  IFID_FULL  = 2'd2;

endpackage

// File: rtl/core_if_id_skid_ff.sv
// gen_en_ff_n: width-parametrised register with load enable and an
// asynchronous active-low reset that loads the rst_val input.
// Ports: clk, rst_n (async, active-low), en (load enable),
//        rst_val (value taken on reset), d (next value), q (register).
module gen_en_ff_n #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/core_if_id_skid.sv
// core_if_id_skid: IF/ID pipeline register with valid/ready handshake, flush
// and an optional 2-entry skid buffer.
// Ports:
//   clk, rst (async, active-low), flush_i (discard everything held/incoming)
//   in_valid/in_ready/in_addr/in_inst     : fetch side
//   out_valid/out_ready/out_addr/out_inst : decode side (driven by main flops)
//   occupancy                              : entries held (0..2)
// With SKID=1 in_ready comes straight from a flop; with SKID=0 there is no
// skid entry and in_ready is ~out_valid | out_ready.
module core_if_id_skid
    import core_if_id_skid_pkg::*;
#(
    parameter int                 ADDR_W   = InstAddressBus,
    parameter int                 INST_W   = InstByteBus,
    parameter logic [ADDR_W-1:0]  RST_ADDR = ADDR_W'(CPURstAddress),
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(INST_NOP),
    parameter int                 SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic              main_en, skid_en;
    logic              in_ready_q, in_ready_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != IFID_EMPTY);
    assign out_addr  = main_addr_q;
    assign out_inst  = main_inst_q;
    assign occupancy = state_q;

    assign in_ready = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_en     = 1'b0;
        skid_en     = 1'b0;
        main_addr_d = main_addr_q;
        main_inst_d = main_inst_q;
        skid_addr_d = skid_addr_q;
        skid_inst_d = skid_inst_q;

        if (flush_i) begin
            // Redirect: drop both entries and anything fetched this cycle.
            state_d     = IFID_EMPTY;
            main_en     = 1'b1;
            skid_en     = 1'b1;
            main_addr_d = RST_ADDR;
            main_inst_d = NOP_INST;
            skid_addr_d = RST_ADDR;
            skid_inst_d = NOP_INST;
        end else begin
            case (state_q)
                IFID_EMPTY: begin
                    if (in_fire) begin
                        state_d     = IFID_ONE;
                        main_en     = 1'b1;
                        main_addr_d = in_addr;
                        main_inst_d = in_inst;
                    end
                end
                IFID_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en     = 1'b1;
                        main_addr_d = in_addr;
                        main_inst_d = in_inst;
                    end else if (in_fire && (SKID != 0)) begin
                        // Decode stalled: park the new word behind the main entry.
                        state_d     = IFID_FULL;
                        skid_en     = 1'b1;
                        skid_addr_d = in_addr;
                        skid_inst_d = in_inst;
                    end else if (!in_fire && out_fire) begin
                        state_d     = IFID_EMPTY;
                        main_en     = 1'b1;
                        main_addr_d = RST_ADDR;
                        main_inst_d = NOP_INST;
                    end
                end
                IFID_FULL: begin
                    if (out_fire) begin
                        state_d     = IFID_ONE;
                        main_en     = 1'b1;
                        skid_en     = 1'b1;
                        main_addr_d = skid_addr_q;
                        main_inst_d = skid_inst_q;
                        skid_addr_d = RST_ADDR;
                        skid_inst_d = NOP_INST;
                    end
                end
                default: begin
                    state_d = IFID_EMPTY;
                end
            endcase
        end

        // Registered ready: next cycle can accept unless we are about to be full.
        in_ready_d = (state_d != IFID_FULL);
    end

    gen_en_ff_n #(.W(2)) u_state_ff (
        .clk(clk), .rst_n(rst), .en(1'b1), .rst_val(IFID_EMPTY),
        .d(state_d), .q(state_q)
    );

    gen_en_ff_n #(.W(1)) u_in_ready_ff (
        .clk(clk), .rst_n(rst), .en(1'b1), .rst_val(1'b1),
        .d(in_ready_d), .q(in_ready_q)
    );

    gen_en_ff_n #(.W(ADDR_W)) u_main_addr_ff (
        .clk(clk), .rst_n(rst), .en(main_en), .rst_val(RST_ADDR),
        .d(main_addr_d), .q(main_addr_q)
    );

    gen_en_ff_n #(.W(INST_W)) u_main_inst_ff (
        .clk(clk), .rst_n(rst), .en(main_en), .rst_val(NOP_INST),
        .d(main_inst_d), .q(main_inst_q)
    );

    gen_en_ff_n #(.W(ADDR_W)) u_skid_addr_ff (
        .clk(clk), .rst_n(rst), .en(skid_en), .rst_val(RST_ADDR),
        .d(skid_addr_d), .q(skid_addr_q)
    );

    gen_en_ff_n #(.W(INST_W)) u_skid_inst_ff (
        .clk(clk), .rst_n(rst), .en(skid_en), .rst_val(NOP_INST),
        .d(skid_inst_d), .q(skid_inst_q)
    );

endmodule

// File: tb/tb_core_if_id_skid.sv
// Directed bench for core_if_id_skid: one SKID=1 and one SKID=0 instance
// share all inputs; each step checks outputs 1 time unit after the clock edge.
module tb_core_if_id_skid;

    localparam logic [31:0] RA  = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [31:0] out_addr1, out_inst1;
    logic [1:0]  occ1;
    logic        in_ready0, out_valid0;
    logic [31:0] out_addr0, out_inst0;
    logic [1:0]  occ0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_if_id_skid #(.SKID(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready1), .in_addr(in_addr), .in_inst(in_inst),
        .out_valid(out_valid1), .out_ready(out_ready), .out_addr(out_addr1),
        .out_inst(out_inst1), .occupancy(occ1)
    );

    core_if_id_skid #(.SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready0), .in_addr(in_addr), .in_inst(in_inst),
        .out_valid(out_valid0), .out_ready(out_ready), .out_addr(out_addr0),
        .out_inst(out_inst0), .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full check of the SKID=1 instance's decode side.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] i, input logic [1:0] o, input logic r);
        $display("step %s: valid=%0b addr=%h inst=%h occ=%0d in_ready=%0b",
                 tag, out_valid1, out_addr1, out_inst1, occ1, in_ready1);
        chk({tag, ".valid"}, 64'(out_valid1), 64'(v));
        chk({tag, ".addr"},  64'(out_addr1),  64'(a));
        chk({tag, ".inst"},  64'(out_inst1),  64'(i));
        chk({tag, ".occ"},   64'(occ1),       64'(o));
        chk({tag, ".rdy"},   64'(in_ready1),  64'(r));
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic ordy, input logic fl);
        in_valid  = v;
        in_addr   = a;
        in_inst   = 32'h0050_0093 + a;
        out_ready = ordy;
        flush_i   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("reset", 1'b0, RA, NOP, 2'd0, 1'b1);
        rst = 1'b1;

        // First instruction and streaming with decode always ready.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(4 * k), 1'b1, 1'b0);
            tick();
            chk_out($sformatf("stream%0d", k), 1'b1, 32'(4 * k), 32'h0050_0093 + 32'(4 * k), 2'd1, 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("drain", 1'b0, RA, NOP, 2'd0, 1'b1);

        // Skid fill with decode stalled, then release.
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        chk_out("skid1", 1'b1, 32'h10, 32'h0050_00a3, 2'd1, 1'b1);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        tick();
        chk_out("skid2", 1'b1, 32'h10, 32'h0050_00a3, 2'd2, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 1'b0);
        tick();
        chk_out("skid3", 1'b1, 32'h10, 32'h0050_00a3, 2'd2, 1'b0);
        drive(1'b1, 32'h18, 1'b1, 1'b0);
        tick();
        chk_out("rel14", 1'b1, 32'h14, 32'h0050_00a7, 2'd1, 1'b1);
        tick();
        chk_out("rel18", 1'b1, 32'h18, 32'h0050_00ab, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("relE", 1'b0, RA, NOP, 2'd0, 1'b1);

        // Flush from FULL; flushed entries never reappear.
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        tick();
        chk_out("fillF", 1'b1, 32'h20, 32'h0050_00b3, 2'd2, 1'b0);
        drive(1'b1, 32'h28, 1'b0, 1'b1);
        tick();
        chk_out("flush", 1'b0, RA, NOP, 2'd0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("postfl", 1'b0, RA, NOP, 2'd0, 1'b1);
        // Flush while EMPTY with an accepted offer: the offer is discarded.
        drive(1'b1, 32'h30, 1'b1, 1'b1);
        tick();
        chk_out("flushin", 1'b0, RA, NOP, 2'd0, 1'b1);

        // Asynchronous reset mid-cycle while FULL.
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        chk_out("fillR", 1'b1, 32'h40, 32'h0050_00d3, 2'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("asyncrst", 1'b0, RA, NOP, 2'd0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        tick();
        chk_out("afterrst", 1'b1, 32'h50, 32'h0050_00e3, 2'd1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("s0.empty", 64'(occ0), 64'd0);

        // SKID=0: combinational ready, no bubble on replacement.
        drive(1'b1, 32'h60, 1'b0, 1'b0);
        tick();
        $display("step s0load: valid=%0b addr=%h occ=%0d in_ready=%0b", out_valid0, out_addr0, occ0, in_ready0);
        chk("s0.valid", 64'(out_valid0), 64'd1);
        chk("s0.addr",  64'(out_addr0),  64'h60);
        chk("s0.rdy0",  64'(in_ready0),  64'd0);
        drive(1'b1, 32'h64, 1'b0, 1'b0);
        tick();
        $display("step s0hold: valid=%0b addr=%h occ=%0d in_ready=%0b", out_valid0, out_addr0, occ0, in_ready0);
        chk("s0.holda", 64'(out_addr0), 64'h60);
        chk("s0.holdo", 64'(occ0),      64'd1);
        drive(1'b1, 32'h64, 1'b1, 1'b0);
        #1;
        chk("s0.rdy1", 64'(in_ready0), 64'd1);
        tick();
        $display("step s0repl: valid=%0b addr=%h occ=%0d in_ready=%0b", out_valid0, out_addr0, occ0, in_ready0);
        chk("s0.repv", 64'(out_valid0), 64'd1);
        chk("s0.repa", 64'(out_addr0),  64'h64);
        chk("s0.repi", 64'(out_inst0),  64'h0050_00f7);
        chk("s0.repo", 64'(occ0),       64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
